// File: rtl/branch_resolve_if.sv
// branch_resolve_if: record-in / record-out bundle of the branch resolution stage.
// BRANCH_RESOLVE_STATS_EN adds the two statistics counters.
interface branch_resolve_if #(parameter int XLEN = 32);
   logic            i_valid, o_ready, i_is_branch, i_is_jal, i_is_jalr, i_pred_taken;
   logic [XLEN-1:0] i_pc, i_imm, i_rs1, i_cmp_result;
   logic            o_valid, i_ready, o_taken, o_redirect;
   logic [XLEN-1:0] o_link, o_target;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0]     o_stat_branches, o_stat_mispred;
`endif
   modport slave (
      input  i_valid, i_is_branch, i_is_jal, i_is_jalr, i_pred_taken,
      input  i_pc, i_imm, i_rs1, i_cmp_result, i_ready,
      output o_ready, o_valid, o_taken, o_redirect, o_link, o_target
`ifdef BRANCH_RESOLVE_STATS_EN
      , output o_stat_branches, o_stat_mispred
`endif
   );
   modport master (
      output i_valid, i_is_branch, i_is_jal, i_is_jalr, i_pred_taken,
      output i_pc, i_imm, i_rs1, i_cmp_result, i_ready,
      input  o_ready, o_valid, o_taken, o_redirect, o_link, o_target
`ifdef BRANCH_RESOLVE_STATS_EN
      , input o_stat_branches, o_stat_mispred
`endif
   );
endinterface

// File: rtl/branch_resolve.sv
// branch_resolve: execute-stage branch/jump resolution with redirect and wrong-path flush.
// BRANCH_RESOLVE_STATS_EN adds saturating branch/mispredict counters.
module branch_resolve #(
   parameter int XLEN         = 32,
   parameter int FLUSH_CYCLES = 2
) (
   input logic             i_clk,
   input logic             i_rst,
   branch_resolve_if.slave bus
);
   localparam int CW = (FLUSH_CYCLES > 0) ? $clog2(FLUSH_CYCLES + 1) : 1;
   typedef enum logic {RUN, FLUSH} state_e;
   state_e          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            valid_q, valid_d, taken_q, taken_d, redirect_q, redirect_d;
   logic [XLEN-1:0] link_q, link_d, target_q, target_d;
   logic            ready, acc, ctrl, taken, mispred, unused_cmp;
   logic [XLEN-1:0] link, tgt_taken;
   assign unused_cmp = ^bus.i_cmp_result[XLEN-1:1];
   assign ready      = (state_q == FLUSH) | ~valid_q | bus.i_ready;
   assign acc        = (state_q == RUN) & bus.i_valid & ready;
   assign ctrl       = bus.i_is_branch | bus.i_is_jal | bus.i_is_jalr;
   assign taken      = bus.i_is_jal | bus.i_is_jalr | (bus.i_is_branch & bus.i_cmp_result[0]);
   // JALR never matches a prediction since the front end has no target predictor
   assign mispred    = bus.i_is_jalr | (ctrl & (taken != bus.i_pred_taken));
   assign link       = bus.i_pc + XLEN'(4);
   assign tgt_taken  = bus.i_is_jalr ? ((bus.i_rs1 + bus.i_imm) & ~XLEN'(1)) : (bus.i_pc + bus.i_imm);
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      valid_d    = acc | (valid_q & ~bus.i_ready);
      taken_d    = acc ? taken : taken_q;
      link_d     = acc ? link : link_q;
      redirect_d = acc & mispred;
      target_d   = acc ? (taken ? tgt_taken : link) : target_q;
      if (state_q == RUN) begin
         if (acc & mispred & (FLUSH_CYCLES > 0)) begin
            state_d = FLUSH;
            cnt_d   = CW'(FLUSH_CYCLES);
         end
      end else if (bus.i_valid) begin
         cnt_d = cnt_q - CW'(1);
         if (cnt_q == CW'(1)) state_d = RUN;
      end
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         state_q    <= RUN;
         cnt_q      <= '0;
         valid_q    <= 1'b0;
         taken_q    <= 1'b0;
         redirect_q <= 1'b0;
         link_q     <= '0;
         target_q   <= '0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         valid_q    <= valid_d;
         taken_q    <= taken_d;
         redirect_q <= redirect_d;
         link_q     <= link_d;
         target_q   <= target_d;
      end
   end
   assign bus.o_ready    = ready;
   assign bus.o_valid    = valid_q;
   assign bus.o_taken    = taken_q;
   assign bus.o_redirect = redirect_q;
   assign bus.o_link     = link_q;
   assign bus.o_target   = target_q;
`ifdef BRANCH_RESOLVE_STATS_EN
   logic [31:0] br_q, br_d, mp_q, mp_d;
   always_comb begin
      br_d = br_q + 32'(acc & ctrl & (br_q != '1));
      mp_d = mp_q + 32'(acc & mispred & (mp_q != '1));
   end
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         br_q <= '0;
         mp_q <= '0;
      end else begin
         br_q <= br_d;
         mp_q <= mp_d;
      end
   end
   assign bus.o_stat_branches = br_q;
   assign bus.o_stat_mispred  = mp_q;
`endif
endmodule

// File: tb/tb_branch_resolve.sv
// tb_branch_resolve: directed self-checking bench for branch_resolve (FLUSH_CYCLES=2).
module tb_branch_resolve;
   logic clk = 1'b0;
   logic rst = 1'b1;
   int   checks = 0;
   int   errors = 0;
   branch_resolve_if #(.XLEN(32)) bus ();
   branch_resolve #(.XLEN(32), .FLUSH_CYCLES(2)) dut (.i_clk(clk), .i_rst(rst), .bus(bus));
   initial forever #5 clk = ~clk;

   task automatic drive(input logic v, br, jal, jalr, pred, input logic [31:0] pc, imm, rs1, cmp);
      bus.i_valid = v; bus.i_is_branch = br; bus.i_is_jal = jal; bus.i_is_jalr = jalr;
      bus.i_pred_taken = pred; bus.i_pc = pc; bus.i_imm = imm; bus.i_rs1 = rs1; bus.i_cmp_result = cmp;
   endtask

   task automatic idle();
      drive(0, 0, 0, 0, 0, 32'h0, 32'h0, 32'h0, 32'h0);
   endtask

   task automatic cycle();
      @(posedge clk); #1;
   endtask

   task automatic test_reset();
      idle(); bus.i_ready = 1'b1; rst = 1'b1;
      cycle(); cycle();
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %0h want 0", bus.o_valid); end
      checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL rst_redirect got %0h want 0", bus.o_redirect); end
      checks++; if (bus.o_taken !== 1'b0) begin errors++; $display("FAIL rst_taken got %0h want 0", bus.o_taken); end
      checks++; if (bus.o_link !== 32'h0) begin errors++; $display("FAIL rst_link got %08h want 0", bus.o_link); end
      checks++; if (bus.o_target !== 32'h0) begin errors++; $display("FAIL rst_target got %08h want 0", bus.o_target); end
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL rst_ready got %0h want 1", bus.o_ready); end
      rst = 1'b0;
   endtask

   task automatic test_beq_mispredict();
      drive(1, 1, 0, 0, 0, 32'h100, 32'h20, 32'h0, 32'h1);
      cycle();
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL beq_valid got %0h want 1", bus.o_valid); end
      checks++; if (bus.o_taken !== 1'b1) begin errors++; $display("FAIL beq_taken got %0h want 1", bus.o_taken); end
      checks++; if (bus.o_redirect !== 1'b1) begin errors++; $display("FAIL beq_redirect got %0h want 1", bus.o_redirect); end
      checks++; if (bus.o_target !== 32'h120) begin errors++; $display("FAIL beq_target got %08h want 00000120", bus.o_target); end
      checks++; if (bus.o_link !== 32'h104) begin errors++; $display("FAIL beq_link got %08h want 00000104", bus.o_link); end
      drive(1, 0, 0, 0, 0, 32'h500, 32'h0, 32'h0, 32'h0);
      cycle();
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL drop1_valid got %0h want 0", bus.o_valid); end
      checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL drop1_redirect got %0h want 0", bus.o_redirect); end
      idle();
      cycle();
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL flush_hold_ready got %0h want 1", bus.o_ready); end
      drive(1, 1, 0, 0, 0, 32'h504, 32'h8, 32'h0, 32'h1);
      cycle();
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL drop2_valid got %0h want 0", bus.o_valid); end
      checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL drop2_redirect got %0h want 0", bus.o_redirect); end
      drive(1, 0, 0, 0, 0, 32'h600, 32'h0, 32'h0, 32'h0);
      cycle();
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL post_flush_valid got %0h want 1", bus.o_valid); end
      checks++; if (bus.o_link !== 32'h604) begin errors++; $display("FAIL post_flush_link got %08h want 00000604", bus.o_link); end
      idle();
      cycle();
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL drain_valid got %0h want 0", bus.o_valid); end
   endtask

   task automatic test_back_to_back();
      drive(1, 1, 0, 0, 0, 32'h200, 32'h10, 32'h0, 32'h0);
      cycle();
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL bne_valid got %0h want 1", bus.o_valid); end
      checks++; if (bus.o_taken !== 1'b0) begin errors++; $display("FAIL bne_taken got %0h want 0", bus.o_taken); end
      checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL bne_redirect got %0h want 0", bus.o_redirect); end
      checks++; if (bus.o_ready !== 1'b1) begin errors++; $display("FAIL bne_ready got %0h want 1", bus.o_ready); end
      drive(1, 0, 0, 0, 1, 32'h210, 32'h0, 32'h0, 32'h1);
      cycle();
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL b2b_valid got %0h want 1", bus.o_valid); end
      checks++; if (bus.o_link !== 32'h214) begin errors++; $display("FAIL b2b_link got %08h want 00000214", bus.o_link); end
      checks++; if (bus.o_taken !== 1'b0) begin errors++; $display("FAIL plain_taken got %0h want 0", bus.o_taken); end
      checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL plain_redirect got %0h want 0", bus.o_redirect); end
      idle();
      cycle();
   endtask

   task automatic test_pred_taken_not_taken();
      drive(1, 1, 0, 0, 1, 32'h300, 32'h40, 32'h0, 32'h0);
      cycle();
      checks++; if (bus.o_redirect !== 1'b1) begin errors++; $display("FAIL pnt_redirect got %0h want 1", bus.o_redirect); end
      checks++; if (bus.o_target !== 32'h304) begin errors++; $display("FAIL pnt_target got %08h want 00000304", bus.o_target); end
      checks++; if (bus.o_taken !== 1'b0) begin errors++; $display("FAIL pnt_taken got %0h want 0", bus.o_taken); end
      drive(1, 0, 0, 0, 0, 32'h900, 32'h0, 32'h0, 32'h0);
      cycle(); cycle();
      idle();
      cycle();
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL pnt_flush_valid got %0h want 0", bus.o_valid); end
   endtask

   task automatic test_jalr_stall();
      drive(1, 0, 0, 1, 1, 32'h400, 32'h4, 32'h1003, 32'h0);
      cycle();
      checks++; if (bus.o_redirect !== 1'b1) begin errors++; $display("FAIL jalr_redirect got %0h want 1", bus.o_redirect); end
      checks++; if (bus.o_target !== 32'h1006) begin errors++; $display("FAIL jalr_target got %08h want 00001006", bus.o_target); end
      checks++; if (bus.o_taken !== 1'b1) begin errors++; $display("FAIL jalr_taken got %0h want 1", bus.o_taken); end
      checks++; if (bus.o_link !== 32'h404) begin errors++; $display("FAIL jalr_link got %08h want 00000404", bus.o_link); end
      bus.i_ready = 1'b0;
      drive(1, 0, 0, 0, 0, 32'hA00, 32'h0, 32'h0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         if (i == 2) idle();
         cycle();
         checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL stall%0d_valid got %0h want 1", i, bus.o_valid); end
         checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL stall%0d_redirect got %0h want 0", i, bus.o_redirect); end
         checks++; if (bus.o_link !== 32'h404) begin errors++; $display("FAIL stall%0d_link got %08h want 00000404", i, bus.o_link); end
      end
      checks++; if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0h want 0", bus.o_ready); end
      bus.i_ready = 1'b1;
      cycle();
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL unstall_valid got %0h want 0", bus.o_valid); end
   endtask

   task automatic test_wrap_and_reset_mid_flush();
      drive(1, 0, 1, 0, 0, 32'hFFFF_FFF8, 32'h10, 32'h0, 32'h0);
      cycle();
      checks++; if (bus.o_target !== 32'h8) begin errors++; $display("FAIL wrap_target got %08h want 00000008", bus.o_target); end
      checks++; if (bus.o_link !== 32'hFFFF_FFFC) begin errors++; $display("FAIL wrap_link got %08h want fffffffc", bus.o_link); end
      checks++; if (bus.o_redirect !== 1'b1) begin errors++; $display("FAIL wrap_redirect got %0h want 1", bus.o_redirect); end
      drive(1, 0, 0, 0, 0, 32'hB00, 32'h0, 32'h0, 32'h0);
      cycle();
      idle(); rst = 1'b1;
      cycle();
      rst = 1'b0;
      checks++; if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL midrst_valid got %0h want 0", bus.o_valid); end
      checks++; if (bus.o_link !== 32'h0) begin errors++; $display("FAIL midrst_link got %08h want 0", bus.o_link); end
`ifdef BRANCH_RESOLVE_STATS_EN
      checks++; if (bus.o_stat_branches !== 32'h0) begin errors++; $display("FAIL midrst_branches got %0d want 0", bus.o_stat_branches); end
      checks++; if (bus.o_stat_mispred !== 32'h0) begin errors++; $display("FAIL midrst_mispred got %0d want 0", bus.o_stat_mispred); end
`endif
      drive(1, 0, 0, 0, 0, 32'h700, 32'h0, 32'h0, 32'h0);
      cycle();
      checks++; if (bus.o_valid !== 1'b1) begin errors++; $display("FAIL after_rst_valid got %0h want 1", bus.o_valid); end
      checks++; if (bus.o_link !== 32'h704) begin errors++; $display("FAIL after_rst_link got %08h want 00000704", bus.o_link); end
      drive(1, 1, 0, 0, 1, 32'h800, 32'h20, 32'h0, 32'h1);
      cycle();
`ifdef BRANCH_RESOLVE_STATS_EN
      checks++; if (bus.o_stat_branches !== 32'h1) begin errors++; $display("FAIL stat_branches got %0d want 1", bus.o_stat_branches); end
      checks++; if (bus.o_stat_mispred !== 32'h0) begin errors++; $display("FAIL stat_mispred got %0d want 0", bus.o_stat_mispred); end
`endif
      checks++; if (bus.o_target !== 32'h820) begin errors++; $display("FAIL pred_ok_target got %08h want 00000820", bus.o_target); end
      checks++; if (bus.o_redirect !== 1'b0) begin errors++; $display("FAIL pred_ok_redirect got %0h want 0", bus.o_redirect); end
      idle();
      cycle();
   endtask

   initial begin
      test_reset();
      test_beq_mispredict();
      test_back_to_back();
      test_pred_taken_not_taken();
      test_jalr_stall();
      test_wrap_and_reset_mid_flush();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/branch_resolve.md
Name: branch_resolve

Overview:
- Execute-stage branch/jump resolution unit, directly downstream of the ALU comparison block.
- Consumes the comparator's 32-bit result (bit 0 significant), the PC, the immediate and rs1.
- Decides taken/not-taken and computes the target and link address.
- On misprediction, raises a one-cycle PC redirect and then discards FLUSH_CYCLES wrong-path instructions via an internal state machine.
- Output is a registered valid/ready stage toward the memory/writeback path.

Parameters:
- XLEN, 32, datapath width.
- FLUSH_CYCLES, 2, number of upstream instructions dropped after a redirect; 0 disables the FLUSH state.

Ports:
- i_clk  input  1  clock, rising edge.
- i_rst  input  1  synchronous, active-high reset.
- i_valid  input  1  upstream record valid.
- o_ready  output  1  this block can accept a record.
- i_is_branch  input  1  conditional branch (BEQ..BGEU).
- i_is_jal  input  1  JAL.
- i_is_jalr  input  1  JALR.
- i_pred_taken  input  1  front-end prediction for this instruction.
- i_pc  input  XLEN  instruction PC.
- i_imm  input  XLEN  sign-extended immediate.
- i_rs1  input  XLEN  rs1 operand (JALR base).
- i_cmp_result  input  XLEN  comparator output; only bit 0 used.
- o_valid  output  1  output record valid.
- i_ready  input  1  downstream accepts record.
- o_taken  output  1  resolved direction.
- o_link  output  XLEN  i_pc+4, registered.
- o_redirect  output  1  one-cycle pulse, redirect fetch.
- o_target  output  XLEN  redirect PC; valid while o_redirect=1.

Behaviour:
- Reset (i_rst=1 at a rising edge):
  - state=RUN, flush counter=0.
  - o_valid=0, o_redirect=0, o_taken=0, o_link=0, o_target=0.
  - Reset overrides everything, including mid-FLUSH; it takes effect the same edge.
- Accept condition:
  - RUN: acc = i_valid & o_ready, with o_ready = ~o_valid | i_ready.
  - FLUSH: o_ready=1 and incoming records are discarded. They never reach the output and never cause a redirect.
- Resolution, combinational on the accepted record:
  - taken = i_is_jal | i_is_jalr | (i_is_branch & i_cmp_result[0]).
  - tgt_taken = i_is_jalr ? ((i_rs1+i_imm) & ~1) : (i_pc+i_imm). All adds are modulo 2^XLEN; wrap-around is legal and not flagged.
  - mispredict = i_is_jalr | (taken != i_pred_taken). JALR always redirects (no target prediction).
  - redirect target = taken ? tgt_taken : i_pc+4.
  - If no control flag is set: taken=0 and mispredict=0 regardless of i_pred_taken. The record passes through as plain ALU traffic.
  - More than one of i_is_branch/i_is_jal/i_is_jalr set is illegal. Priority is jalr > jal > branch.
- Latency: 1 cycle.
  - On acc, at the next edge: o_valid=1; o_taken and o_link load.
  - o_redirect=mispredict for exactly that one cycle; o_target loads with it.
  - o_valid/o_taken/o_link then hold while ~i_ready (stall). o_redirect never repeats during a stall.
  - o_valid clears when i_ready=1 and there is no new acc.
- State machine:
  - RUN -> FLUSH on an accepted mispredict when FLUSH_CYCLES>0; counter=FLUSH_CYCLES.
  - FLUSH: the counter decrements only on cycles where i_valid=1, dropping that record. At 1->0 the state returns to RUN.
  - FLUSH with i_valid=0: the state holds.
  - The output register still drains in FLUSH: o_valid clears on i_ready.
- Back-to-back: with i_ready=1, one record per cycle in RUN; o_ready stays 1 in RUN while the output register is empty or draining.

Optional Feature:
- Macro: BRANCH_RESOLVE_STATS_EN.
- Defined:
  - Adds outputs o_stat_branches [31:0] and o_stat_mispred [31:0]. Both reset to 0.
  - o_stat_branches increments on every accepted record with any control flag set.
  - o_stat_mispred increments on every accepted mispredict.
  - Counters saturate at 32'hFFFF_FFFF; discarded FLUSH records are not counted.
- Not defined: neither port nor counter exists; all other behaviour is identical.

Test Plan:
- BEQ taken, mispredicted: pc=0x100, imm=0x20, cmp=1, pred=0 -> next cycle o_valid=1, o_taken=1, o_redirect=1 for one cycle, o_target=0x120, o_link=0x104. The next 2 i_valid records are dropped (no o_valid).
- BNE correct not-taken: pc=0x200, cmp=0, pred=0 -> o_taken=0, o_redirect=0, no FLUSH; the following record appears at the output 1 cycle after acceptance.
- Predicted-taken but not-taken: pc=0x300, imm=0x40, cmp=0, pred=1 -> o_redirect=1, o_target=0x304.
- JALR: rs1=0x1003, imm=0x4, pred=1 -> o_redirect=1, o_target=0x1006, o_taken=1. Then hold i_ready=0 for 3 cycles: o_valid stays 1, o_redirect=0 after the first cycle, o_ready=0.
- Wrap: JAL pc=0xFFFF_FFF8, imm=0x10, pred=0 -> o_target=0x0000_0008, o_link=0xFFFF_FFFC.
- Reset mid-FLUSH: after a mispredict, assert i_rst for one cycle after 1 record is dropped -> o_valid=0, state RUN. The next i_valid record is accepted and output normally. With BRANCH_RESOLVE_STATS_EN defined, both counters read 0.
